recognize_sched: RTL and testbench

- Time-multiplexes one "110" sequence-recognizer next-state datapath across NCH independent serial bit channels.
- Holds a saved 2-bit recognizer state per channel and grants one channel per cycle, round-robin.
- Steps the granted channel's state with its bit, writes the result back, and reports a match when a channel enters S3.
- Sits between the serial input channels and the downstream match consumer.

---
 rtl/recognize_sched.sv | 177 +++++++++++++++++
 tb/tb_recognize_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/recognize_sched.sv
`default_nettype none
// ============================================================================
//  Module   : recognize_sched
//  Function : Round-robin scheduler that time-multiplexes a single "110"
//             recognizer next-state datapath across NCH serial bit channels.
//             Each channel keeps a saved 2-bit recognizer state. One channel
//             is granted per cycle. A match pulse is registered when the
//             granted channel enters S3.
//  Options  : RECOG_SCHED_STATS_EN - per-channel saturating match counters,
//             read back through rd_ch / rd_count.
//  Revision : 1.0 - initial release
// ============================================================================
module recognize_sched #(
    parameter int NCH   = 4,
    parameter int CH_W  = 2,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    bit_valid,
    input  logic [NCH-1:0]    bit_in,
    output logic [NCH-1:0]    bit_ready,
    input  logic [NCH-1:0]    clear,
    output logic              match_valid,
    output logic [CH_W-1:0]   match_ch,
    output logic [2*NCH-1:0]  ctx_st,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [CNT_W-1:0]  rd_count
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } rec_st_t;

    rec_st_t          r_ctx [NCH];
    logic [CH_W-1:0]  r_ptr;
    logic             r_match_valid;
    logic [CH_W-1:0]  r_match_ch;

    logic [NCH-1:0]   w_elig;
    logic             w_hit_hi;
    logic             w_hit_lo;
    logic [CH_W-1:0]  w_g_hi;
    logic [CH_W-1:0]  w_g_lo;
    logic             w_grant_any;
    logic [CH_W-1:0]  w_grant_ch;
    logic [CH_W-1:0]  w_ptr_nxt;
    rec_st_t          w_cur;
    logic             w_bit;
    rec_st_t          w_next;
    logic             w_hit_s3;

    // A channel being cleared never competes for the datapath.
    assign w_elig = bit_valid & ~clear;

    // Round-robin search: lowest eligible index at or above the pointer,
    // otherwise wrap around to the lowest eligible index overall.
    always_comb begin
        w_hit_hi = 1'b0;
        w_hit_lo = 1'b0;
        w_g_hi   = '0;
        w_g_lo   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                if (CH_W'(i) >= r_ptr) begin
                    w_hit_hi = 1'b1;
                    w_g_hi   = CH_W'(i);
                end
                w_hit_lo = 1'b1;
                w_g_lo   = CH_W'(i);
            end
        end
    end

    assign w_grant_any = w_hit_lo;
    assign w_grant_ch  = w_hit_hi ? w_g_hi : w_g_lo;
    assign w_ptr_nxt   = (w_grant_ch == CH_W'(NCH - 1)) ? '0 : w_grant_ch + 1'b1;

    // One-hot consume strobe for the granted channel.
    always_comb begin
        bit_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            bit_ready[i] = w_grant_any && (w_grant_ch == CH_W'(i));
        end
    end

    // Shared datapath: fetch the granted context and bit, compute next state.
    always_comb begin
        w_cur  = S0;
        w_bit  = 1'b0;
        w_next = S0;
        for (int i = 0; i < NCH; i++) begin
            if (w_grant_ch == CH_W'(i)) begin
                w_cur = r_ctx[i];
                w_bit = bit_in[i];
            end
        end
        case (w_cur)
            S0:      w_next = w_bit ? S1 : S0;
            S1:      w_next = w_bit ? S2 : S0;
            S2:      w_next = w_bit ? S2 : S3;
            S3:      w_next = w_bit ? S1 : S0;
            default: w_next = S0;
        endcase
    end

    assign w_hit_s3 = w_grant_any && (w_next == S3);

    // Context write-back; clear takes priority over a grant (which it also blocks).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) r_ctx[i] <= S0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clear[i])          r_ctx[i] <= S0;
                else if (bit_ready[i]) r_ctx[i] <= w_next;
            end
        end
    end

    // Pointer advance past the granted channel and registered match report.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr         <= '0;
            r_match_valid <= 1'b0;
            r_match_ch    <= '0;
        end else begin
            if (w_grant_any) r_ptr <= w_ptr_nxt;
            r_match_valid <= w_hit_s3;
            if (w_hit_s3) r_match_ch <= w_grant_ch;
        end
    end

    assign match_valid = r_match_valid;
    assign match_ch    = r_match_ch;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_pack
            assign ctx_st[2*gi +: 2] = r_ctx[gi];
        end
    endgenerate

`ifdef RECOG_SCHED_STATS_EN
    logic [CNT_W-1:0] r_cnt [NCH];

    // Saturating per-channel match counters; clear zeroes and wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clear[i])
                    r_cnt[i] <= '0;
                else if (w_hit_s3 && bit_ready[i] && (r_cnt[i] != '1))
                    r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

    // Counter read mux; out-of-range selects read as zero.
    always_comb begin
        rd_count = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_ch == CH_W'(i)) rd_count = r_cnt[i];
        end
    end
`else
    logic w_unused_rd;
    assign w_unused_rd = ^rd_ch;
    assign rd_count    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_recognize_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_recognize_sched
//  Function : Self-checking bench for recognize_sched. Directed stimulus
//             pushes expected match reports into a scoreboard queue; a
//             negedge monitor pops and compares them against the DUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_recognize_sched;

    localparam int NCH   = 4;
    localparam int CH_W  = 2;
    localparam int CNT_W = 2;

    logic              clk;
    logic              reset;
    logic [NCH-1:0]    bit_valid;
    logic [NCH-1:0]    bit_in;
    logic [NCH-1:0]    bit_ready;
    logic [NCH-1:0]    clear;
    logic              match_valid;
    logic [CH_W-1:0]   match_ch;
    logic [2*NCH-1:0]  ctx_st;
    logic [CH_W-1:0]   rd_ch;
    logic [CNT_W-1:0]  rd_count;

    recognize_sched #(.NCH(NCH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .bit_ready   (bit_ready),
        .clear       (clear),
        .match_valid (match_valid),
        .match_ch    (match_ch),
        .ctx_st      (ctx_st),
        .rd_ch       (rd_ch),
        .rd_count    (rd_count)
    );

    typedef struct {
        int ch;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every reported match must be the next expected one, on its cycle.
    always @(negedge clk) begin
        if (!reset && match_valid) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_match: got ch %0d at cycle %0d, expected none", match_ch, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("match_ch", 32'(match_ch), e.ch);
                chk("match_cycle", cyc, e.cyc);
            end
        end
    end

    // Apply one cycle of inputs, check the grant, consume on the next edge.
    task automatic send(input logic [3:0] v, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] rdy, input int mch);
        bit_valid = v;
        bit_in    = b;
        clear     = c;
        #1;
        chk("bit_ready", 32'(bit_ready), 32'(rdy));
        if (mch >= 0) exp_q.push_back('{mch, cyc + 1});
        @(posedge clk);
        #1;
        bit_valid = '0;
        bit_in    = '0;
        clear     = '0;
    endtask

    logic [3:0] t3_v   [10] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hC, 4'hC, 4'h4};
    logic [3:0] t3_b   [10] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hC, 4'hC, 4'h0, 4'h0};
    logic [3:0] t3_r   [10] = '{4'h2, 4'h4, 4'h8, 4'h2, 4'h4, 4'h8, 4'h2, 4'h4, 4'h8, 4'h4};
    int         t3_m   [10] = '{-1, -1, -1, -1, -1, -1, 1, -1, 3, 2};
    logic [7:0] t3_ctx [10] = '{8'h04, 8'h14, 8'h54, 8'h58, 8'h68, 8'hA8, 8'hAC, 8'hAC, 8'hEC, 8'hFC};

    initial begin
        int exp_cnt;
        reset     = 1'b1;
        bit_valid = '0;
        bit_in    = '0;
        clear     = '0;
        rd_ch     = '0;
        #3;
        chk("reset_ctx", 32'(ctx_st), 0);
        chk("reset_match_valid", 32'(match_valid), 0);
        chk("reset_match_ch", 32'(match_ch), 0);
        chk("reset_bit_ready", 32'(bit_ready), 0);
        chk("reset_rd_count", 32'(rd_count), 0);
        #9 reset = 1'b0;
        @(posedge clk);
        #1;

        // Channel 0 alone: 1,1,0 -> S1,S2,S3 and one match.
        send(4'h1, 4'h1, 4'h0, 4'h1, -1);
        chk("t1_ctx0_s1", 32'(ctx_st[1:0]), 1);
        send(4'h1, 4'h1, 4'h0, 4'h1, -1);
        chk("t1_ctx0_s2", 32'(ctx_st[1:0]), 2);
        send(4'h1, 4'h0, 4'h0, 4'h1, 0);
        chk("t1_ctx0_s3", 32'(ctx_st[1:0]), 3);
`ifdef RECOG_SCHED_STATS_EN
        chk("t1_count0", 32'(rd_count), 1);
`else
        chk("t1_count0", 32'(rd_count), 0);
`endif

        // All channels pending: strict rotation from pointer 1.
        for (int k = 0; k < 8; k++) begin
            send(4'hF, 4'h0, 4'h0, 4'b0001 << ((1 + k) % 4), -1);
        end
        chk("t2_ctx_all_s0", 32'(ctx_st), 0);

        // Interleaved streams on channels 1,2,3.
        for (int r = 0; r < 10; r++) begin
            send(t3_v[r], t3_b[r], 4'h0, t3_r[r], t3_m[r]);
            chk("t3_ctx", 32'(ctx_st), 32'(t3_ctx[r]));
        end

        // Clear beats a pending bit on channel 2 while at S2.
        send(4'h0, 4'h0, 4'hF, 4'h0, -1);
        chk("t4_clear_all", 32'(ctx_st), 0);
        send(4'h4, 4'h4, 4'h0, 4'h4, -1);
        send(4'h4, 4'h4, 4'h0, 4'h4, -1);
        chk("t4_ctx2_s2", 32'(ctx_st), 32'h20);
        send(4'h5, 4'h0, 4'h4, 4'h1, -1);
        chk("t4_ctx_cleared", 32'(ctx_st), 0);
        chk("t4_no_match", 32'(match_valid), 0);

        // Asynchronous reset in mid-cycle with channel 1 at S2.
        send(4'h2, 4'h2, 4'h0, 4'h2, -1);
        send(4'h2, 4'h2, 4'h0, 4'h2, -1);
        chk("t6_ctx1_s2", 32'(ctx_st), 32'h08);
        chk("t6_match_ch_before", 32'(match_ch), 2);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_ctx", 32'(ctx_st), 0);
        chk("t6_rst_match_ch", 32'(match_ch), 0);
        chk("t6_rst_match_valid", 32'(match_valid), 0);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        send(4'h2, 4'h0, 4'h0, 4'h2, -1);
        send(4'h2, 4'h2, 4'h0, 4'h2, -1);
        send(4'h2, 4'h2, 4'h0, 4'h2, -1);
        send(4'h2, 4'h0, 4'h0, 4'h2, 1);
        chk("t6_ctx1_s3", 32'(ctx_st), 32'h0C);

        // Five matches on channel 0; counter saturates at 3.
        rd_ch = 2'd0;
        for (int m = 0; m < 5; m++) begin
            send(4'h1, 4'h1, 4'h0, 4'h1, -1);
            send(4'h1, 4'h1, 4'h0, 4'h1, -1);
            send(4'h1, 4'h0, 4'h0, 4'h1, 0);
`ifdef RECOG_SCHED_STATS_EN
            exp_cnt = (m + 1 > 3) ? 3 : m + 1;
`else
            exp_cnt = 0;
`endif
            chk("t5_count", 32'(rd_count), exp_cnt);
        end
        send(4'h0, 4'h0, 4'h1, 4'h0, -1);
        chk("t5_count_cleared", 32'(rd_count), 0);
        chk("t5_ctx0_cleared", 32'(ctx_st[1:0]), 0);

        @(posedge clk);
        #1;
        chk("pending_matches", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
